// File: rtl/wb_rr_arbiter.sv
// Round-robin arbiter sharing the writeback path among execute pipes, with a
// one-entry registered output stage and a saturating lost-arbitration counter.
module wb_rr_arbiter #(
  parameter int unsigned p_num_pipes = 4,
  parameter int unsigned p_msg_bits  = 80,
  parameter int unsigned p_cnt_bits  = 16
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [p_num_pipes-1:0]              req_val,
  output logic [p_num_pipes-1:0]              req_rdy,
  input  logic [p_num_pipes*p_msg_bits-1:0]   req_msg,
  output logic                                out_val,
  input  logic                                out_rdy,
  output logic [p_msg_bits-1:0]               out_msg,
  output logic [$clog2(p_num_pipes)-1:0]      out_src,
  output logic [p_cnt_bits-1:0]               conflict_cnt
);

  localparam int unsigned SrcW = $clog2(p_num_pipes);

  logic                  out_val_q, out_val_d;
  logic [p_msg_bits-1:0] out_msg_q, out_msg_d;
  logic [SrcW-1:0]       out_src_q, out_src_d;
  logic [SrcW-1:0]       ptr_q, ptr_d;
  logic [p_cnt_bits-1:0] cnt_q, cnt_d;

  logic                  can_load;
  logic                  found;
  logic                  fire;
  logic                  lost;
  logic [SrcW-1:0]       win;
  int unsigned           idx;

  // Rotating-priority scan starting at ptr, then next-state for all registers.
  always_comb begin
    found     = 1'b0;
    win       = '0;
    idx       = 0;
    req_rdy   = '0;
    out_val_d = out_val_q;
    out_msg_d = out_msg_q;
    out_src_d = out_src_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;

    can_load = !out_val_q || out_rdy;
    for (int unsigned k = 0; k < p_num_pipes; k++) begin
      idx = 32'(ptr_q) + k;
      if (idx >= p_num_pipes) idx = idx - p_num_pipes;
      if (!found && req_val[SrcW'(idx)]) begin
        found = 1'b1;
        win   = SrcW'(idx);
      end
    end

    fire = found && can_load;
    if (fire) req_rdy[win] = 1'b1;
    lost = |(req_val & ~req_rdy);

    if (fire) begin
      out_val_d = 1'b1;
      out_msg_d = req_msg[32'(win)*p_msg_bits +: p_msg_bits];
      out_src_d = win;
      ptr_d     = (32'(win) == p_num_pipes - 1) ? '0 : win + SrcW'(1);
    end else if (out_val_q && out_rdy) begin
      out_val_d = 1'b0;
    end

    // Saturate rather than wrap so long runs never under-report contention.
    if (lost && (cnt_q != {p_cnt_bits{1'b1}})) cnt_d = cnt_q + p_cnt_bits'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_val_q <= 1'b0;
      out_msg_q <= '0;
      out_src_q <= '0;
      ptr_q     <= '0;
      cnt_q     <= '0;
    end else begin
      out_val_q <= out_val_d;
      out_msg_q <= out_msg_d;
      out_src_q <= out_src_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
    end
  end

  assign out_val      = out_val_q;
  assign out_msg      = out_msg_q;
  assign out_src      = out_src_q;
  assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed plus randomized bench for wb_rr_arbiter against a behavioural model
// of the rotating-priority grant, output stage and saturating conflict count.
module tb_wb_rr_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned MW = 32;
  localparam int unsigned CW = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [N-1:0]      req_val = '0;
  logic [N-1:0]      req_rdy;
  logic [N*MW-1:0]   req_msg = '0;
  logic              out_val;
  logic              out_rdy = 1'b1;
  logic [MW-1:0]     out_msg;
  logic [1:0]        out_src;
  logic [CW-1:0]     conflict_cnt;

  wb_rr_arbiter #(.p_num_pipes(N), .p_msg_bits(MW), .p_cnt_bits(CW)) dut (
    .clk(clk), .rst(rst), .req_val(req_val), .req_rdy(req_rdy), .req_msg(req_msg),
    .out_val(out_val), .out_rdy(out_rdy), .out_msg(out_msg), .out_src(out_src),
    .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [MW-1:0] msgs [N];
  bit            m_val;
  logic [MW-1:0] m_msg;
  int            m_src;
  int            m_ptr;
  int            m_cnt;
  int            last_grant;
  logic [N-1:0]  pend;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_val = 0; m_msg = '0; m_src = 0; m_ptr = 0; m_cnt = 0;
  endtask

  task automatic drive_msgs();
    for (int i = 0; i < N; i++) req_msg[i*MW +: MW] = msgs[i];
  endtask

  // One clock: check grant before the edge, advance the model, check outputs after.
  task automatic cycle(input string tag);
    bit can_load;
    logic [N-1:0] exp_rdy;
    int g;
    drive_msgs();
    #1;
    can_load = !m_val || out_rdy;
    g = -1;
    if (can_load)
      for (int k = 0; k < N; k++)
        if (g < 0 && req_val[(m_ptr + k) % N]) g = (m_ptr + k) % N;
    exp_rdy = (g >= 0) ? N'(1 << g) : '0;
    chk({tag, "_rdy"}, 64'(req_rdy), 64'(exp_rdy));
    if (g >= 0) begin
      m_val = 1; m_msg = msgs[g]; m_src = g; m_ptr = (g + 1) % N;
    end else if (m_val && out_rdy) begin
      m_val = 0;
    end
    if ((req_val & ~exp_rdy) != 0 && m_cnt < (1 << CW) - 1) m_cnt++;
    last_grant = g;
    @(posedge clk);
    #1;
    chk({tag, "_val"}, 64'(out_val), 64'(m_val));
    if (m_val) begin
      chk({tag, "_msg"}, 64'(out_msg), 64'(m_msg));
      chk({tag, "_src"}, 64'(out_src), 64'(m_src));
    end
    chk({tag, "_cnt"}, 64'(conflict_cnt), 64'(m_cnt));
  endtask

  task automatic do_reset();
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    model_reset();
  endtask

  initial begin
    for (int i = 0; i < N; i++) msgs[i] = $urandom;
    model_reset();
    #1;
    chk("reset_val", 64'(out_val), 64'd0);
    chk("reset_cnt", 64'(conflict_cnt), 64'd0);
    chk("reset_src", 64'(out_src), 64'd0);
    chk("reset_msg", 64'(out_msg), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    // Idle after reset
    req_val = '0; out_rdy = 1'b1;
    for (int c = 0; c < 10; c++) cycle("idle");

    // All pipes requesting: expected grant order 0,1,2,3,0,1
    req_val = 4'b1111;
    for (int c = 0; c < 6; c++) begin
      cycle("rotate");
      chk("rotate_order", 64'(last_grant), 64'(c % N));
      msgs[last_grant] = $urandom;
    end

    // Backpressure: load pipe 0, stall 5 cycles with 0110 pending
    do_reset();
    req_val = 4'b0001; out_rdy = 1'b0;
    cycle("bp_load");
    req_val = 4'b0110;
    for (int c = 0; c < 5; c++) cycle("bp_stall");
    chk("bp_cnt5", 64'(conflict_cnt), 64'd5);
    out_rdy = 1'b1;
    cycle("bp_release");
    chk("bp_grant1", 64'(last_grant), 64'd1);
    chk("bp_cnt6", 64'(conflict_cnt), 64'd6);
    req_val = 4'b0100;
    cycle("bp_pipe2");

    // Drain and load in the same cycle, then wrap to ptr 0
    req_val = 4'b1000; msgs[3] = 32'h0000ABCD;
    cycle("dl");
    chk("dl_msg", 64'(out_msg), 64'h0000ABCD);
    chk("dl_src", 64'(out_src), 64'd3);
    req_val = 4'b1111;
    cycle("wrap");
    chk("wrap_grant0", 64'(last_grant), 64'd0);

    // Saturation of the 4-bit counter under sustained contention
    do_reset();
    req_val = 4'b1111; out_rdy = 1'b1;
    for (int c = 0; c < 20; c++) begin
      cycle("sat");
      msgs[last_grant] = $urandom;
    end
    chk("sat_cnt15", 64'(conflict_cnt), 64'd15);

    // Randomized traffic with requesters holding until granted
    do_reset();
    pend = '0;
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < N; i++)
        if (!pend[i] && ($urandom % 2 == 1)) begin
          pend[i] = 1'b1;
          msgs[i] = $urandom;
        end
      req_val = pend;
      out_rdy = ($urandom % 4 != 0);
      cycle("rand");
      if (last_grant >= 0) pend[last_grant] = 1'b0;
    end

    // Async reset between edges while a message is held
    do_reset();
    req_val = 4'b0010; out_rdy = 1'b0;
    cycle("ar_load");
    req_val = '0;
    #2 rst = 1'b0;
    #1 chk("ar_val_drop", 64'(out_val), 64'd0);
    chk("ar_cnt_clear", 64'(conflict_cnt), 64'd0);
    #1 rst = 1'b1;
    model_reset();
    req_val = 4'b1111; out_rdy = 1'b1;
    cycle("ar_after");
    chk("ar_pipe0_first", 64'(out_src), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_rr_arbiter.md
# wb_rr_arbiter

Round-robin arbiter that shares the single writeback/complete path among the execute pipes (ALU, multiplier, load/store, control flow). Each pipe offers a completed instruction over a val/rdy channel. The arbiter grants at most one pipe per cycle with rotating priority, then registers the winner into a one-entry output stage that feeds the writeback/commit unit. It also counts lost-arbitration cycles for performance analysis.

## Interface
- p_num_pipes, 4, number of requesting execute pipes (2..8)
- p_msg_bits, 80, width of one completion message (pc, seq_num, waddr, preg, wdata, wen, packed by the caller)
- p_cnt_bits, 16, width of the conflict counter
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-low
- req_val  in  p_num_pipes  per-pipe message valid
- req_rdy  out  p_num_pipes  per-pipe grant/accept (one-hot or zero)
- req_msg  in  p_num_pipes×p_msg_bits  per-pipe message; pipe i occupies bits [i*p_msg_bits +: p_msg_bits]
- out_val  out  1  registered message valid toward writeback
- out_rdy  in  1  writeback accepts message
- out_msg  out  p_msg_bits  registered message
- out_src  out  $clog2(p_num_pipes)  index of pipe that produced out_msg
- conflict_cnt  out  p_cnt_bits  saturating count of cycles in which a valid requester was not granted

## Operation
- State: output register (out_val, out_msg, out_src), priority pointer ptr (index of highest-priority pipe), and conflict_cnt.
- can_load = !out_val || out_rdy. The output stage accepts a new message only when it is empty or draining in the same cycle.
- Selection is combinational. Scan pipes ptr, ptr+1, …, wrapping modulo p_num_pipes. The first i with req_val[i]=1 is the winner.
- req_rdy[i] = can_load && (i == winner). All bits are 0 when no req_val is set or can_load=0. req_rdy never depends on req_msg.
- Input handshake on pipe i fires when req_val[i] && req_rdy[i]. On the next edge: out_val←1, out_msg←req_msg[i], out_src←i, ptr←(i+1) mod p_num_pipes.
- If out_val && out_rdy and no input handshake fires, then out_val←0. out_msg and out_src hold their old values (don't-care).
- If no handshake fires, ptr holds.
- Drain and load in the same cycle are allowed. This gives full throughput of one message per cycle.
- conflict_cnt increments by 1 on every cycle where at least one req_val[j]=1 has req_rdy[j]=0. This includes cycles stalled by can_load=0. It saturates at all-ones and never wraps.
- Requesters must hold req_val and req_msg stable until granted. The arbiter assumes this and does not check it.
- out_msg is presented unchanged. The arbiter never reorders or modifies message bits.

## Timing
- Reset (rst=0, asynchronous, effective immediately): out_val=0, out_src=0, out_msg=0, ptr=0, conflict_cnt=0. Because out_val=0, req_rdy follows req_val through the combinational grant, with pipe 0 highest priority.
- Reset asserted mid-operation: a message held in the output register is dropped, and out_val drops asynchronously.
- Latency: input handshake in cycle N gives out_val=1 with that message in cycle N+1.
- Throughput: one message per cycle while out_rdy=1.
- Backpressure: with out_val=1 and out_rdy=0, every req_rdy is 0 and the output register holds.
- Wrap-around: a grant to pipe p_num_pipes-1 sets ptr=0.
- Single requester: pipe i is granted on every can_load cycle regardless of ptr.
- Fairness: a continuously valid requester is granted within p_num_pipes grant cycles.

## Test plan
- Reset and idle: with rst low, out_val=0 and conflict_cnt=0. After release with no req_val, out_val stays 0 and req_rdy=0000 for 10 cycles.
- All-request rotation: req_val=1111 continuously, out_rdy=1. Grants are 0,1,2,3,0,1 on consecutive cycles. out_src matches one cycle later. conflict_cnt increments each cycle (3 losers).
- Backpressure: one message held with out_rdy=0 for 5 cycles while req_val=0110. req_rdy=0000 and out_msg is stable. When out_rdy rises, pipe 1 is granted that same cycle and appears the next cycle. conflict_cnt has increased by 5 during the stall and by 1 on the grant cycle.
- Drain+load: out_val=1, out_rdy=1, req_val=1000 with msg 0xABCD. Pipe 3 is granted the same cycle and out_msg=0xABCD next cycle with no bubble.
- Saturation: p_cnt_bits=4 under sustained contention. conflict_cnt reaches 15 and stays at 15.
- Async reset mid-stream: rst pulses low between clock edges while out_val=1. out_val drops before the next edge, and after release ptr=0 (pipe 0 wins first).
